nine_segment_display_scheduler: RTL

- Shares one 3x3 nine-segment LED between NUM_REQ requesters.
- Generates the scan `enable` tick and the phase sequence for `nine_segment_to_six_pin`.
- Swaps the displayed pattern only on frame boundaries (after phase S2 completes), so the matrix never shows a half-scanned mix of two patterns.
- Round-robin arbitration; each granted pattern is held for a requested number of frames.

---
 rtl/nine_seg_pkg.sv | 7 +
 rtl/nine_seg_scan_timer.sv | 34 +++
 rtl/nine_segment_display_scheduler.sv | 90 +++++++++
 3 files changed

// File: rtl/nine_seg_pkg.sv
// nine_seg_pkg: shared types and constants for the nine-segment display scheduler
package nine_seg_pkg;
  localparam int NUM_PHASES = 3;
  typedef logic [8:0] seg_pattern_t;
  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2} scan_phase_t;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHOW = 2'd2} sched_state_t;
endpackage

// File: rtl/nine_seg_scan_timer.sv
// nine_seg_scan_timer: free-running prescaler and phase counter producing scan_enable and frame boundary (dimming blank output with NINE_SEG_DIMMING_EN)
module nine_seg_scan_timer
  import nine_seg_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef NINE_SEG_DIMMING_EN
  input  logic [1:0]  dim_level,
  output logic        blank,
`endif
  output scan_phase_t phase,
  output logic        scan_enable,
  output logic        fb
);
  localparam int PW = $clog2(SCAN_DIV);
  logic [PW-1:0] prescaler;
  assign scan_enable = prescaler == PW'(SCAN_DIV - 1);
  assign fb = scan_enable && phase == scan_phase_t'(2'(NUM_PHASES - 1));
`ifdef NINE_SEG_DIMMING_EN
  assign blank = int'(prescaler) >= SCAN_DIV - (int'(dim_level) * SCAN_DIV) / 4;
`endif
  // prescaler wraps every SCAN_DIV cycles; phase steps on the wrapping cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      phase     <= S0;
    end else begin
      prescaler <= scan_enable ? '0 : prescaler + 1'b1;
      if (scan_enable) phase <= phase == S2 ? S0 : scan_phase_t'(phase + 2'd1);
    end
  end
endmodule

// File: rtl/nine_segment_display_scheduler.sv
// nine_segment_display_scheduler: round-robin sharing of one 3x3 segment matrix, patterns swapped only on frame boundaries (optional NINE_SEG_DIMMING_EN adds dim_level)
module nine_segment_display_scheduler
  import nine_seg_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int SCAN_DIV = 1000,
  parameter int HOLD_W   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
`ifdef NINE_SEG_DIMMING_EN
  input  logic [1:0]                      dim_level,
`endif
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][8:0]         req_pattern,
  input  logic [NUM_REQ-1:0][HOLD_W-1:0]  req_frames,
  output logic                            scan_enable,
  output logic [1:0]                      phase,
  output logic [8:0]                      segments,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);
  localparam int IW = $clog2(NUM_REQ);
  sched_state_t  state;
  logic [IW-1:0] rr, win;
  logic          any, fb;
  seg_pattern_t  pend_pat, held;
  logic [HOLD_W-1:0] pend_frames, remaining;
  scan_phase_t   ph;
  assign phase = ph;
  assign busy  = state != IDLE;
`ifdef NINE_SEG_DIMMING_EN
  logic blank;
  nine_seg_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk(clk), .rst_n(rst_n), .dim_level(dim_level), .blank(blank),
    .phase(ph), .scan_enable(scan_enable), .fb(fb)
  );
  assign segments = blank ? '0 : held;
`else
  nine_seg_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk(clk), .rst_n(rst_n), .phase(ph), .scan_enable(scan_enable), .fb(fb)
  );
  assign segments = held;
`endif
  // round-robin pick: nearest valid index after rr wins (later loop passes override farther ones)
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--)
      if (req_valid[(int'(rr) + i) % NUM_REQ]) begin
        win = IW'((int'(rr) + i) % NUM_REQ);
        any = 1'b1;
      end
  end
  assign req_ready = (state == IDLE && any) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << win : '0;
  // grant in IDLE, swap pattern at the next frame boundary, hold for the requested frame count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr          <= IW'(NUM_REQ - 1);
      grant_id    <= '0;
      pend_pat    <= '0;
      pend_frames <= '0;
      remaining   <= '0;
      held        <= '0;
    end else if (state == IDLE) begin
      if (any) begin
        pend_pat    <= req_pattern[win];
        pend_frames <= req_frames[win] == '0 ? HOLD_W'(1) : req_frames[win];
        grant_id    <= win;
        rr          <= win;
        state       <= LOAD;
      end
    end else if (state == LOAD) begin
      if (fb) begin
        held      <= pend_pat;
        remaining <= pend_frames;
        state     <= SHOW;
      end
    end else if (state == SHOW) begin
      if (fb) begin
        remaining <= remaining - 1'b1;
        if (remaining == HOLD_W'(1)) state <= IDLE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule
